dvg_decoder: RTL and testbench

//  Reader/executor for vector-list memory: on a go strobe, fetches 16-bit DVG instructions

---
 rtl/dvg_pkg.sv | 26 ++
 rtl/dvg_retstack.sv | 40 ++++
 rtl/dvg_decoder.sv | 139 +++++++++++++
 tb/tb_dvg_decoder.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvg_pkg.sv
// Shared definitions for the DVG vector-list decoder: opcodes, FSM states, and
// sign-magnitude to two's-complement conversion.
package dvg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RDLO,
    S_RDHI,
    S_DECODE,
    S_EMIT
  } state_t;

  localparam logic [3:0] OP_LABS = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;
  localparam logic [3:0] OP_JSRL = 4'hC;
  localparam logic [3:0] OP_RTSL = 4'hD;
  localparam logic [3:0] OP_JMPL = 4'hE;
  localparam logic [3:0] OP_SVEC = 4'hF;

  // A negative zero collapses to zero because 0 - 0 wraps to 0.
  function automatic logic [10:0] sm2c(input logic sign, input logic [9:0] mag);
    sm2c = sign ? (11'd0 - {1'b0, mag}) : {1'b0, mag};
  endfunction

endpackage

// File: rtl/dvg_retstack.sv
// Return-address LIFO with a wrapping stack pointer; top is registered and always
// equals the entry below sp, so a pop can use it in the same cycle.
module dvg_retstack #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         dvgclk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_dat,
  output logic [W-1:0] top
);

  localparam int SP_W = $clog2(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp;

  // Overflow and underflow simply wrap; the oldest entry is overwritten.
  always_ff @(posedge dvgclk) begin
    if (reset) begin
      sp  <= '0;
      top <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      sp  <= '0;
      top <= mem[SP_W'(DEPTH - 1)];
    end else if (push) begin
      mem[sp] <= push_dat;
      sp      <= sp + SP_W'(1);
      top     <= push_dat;
    end else if (pop) begin
      sp  <= sp - SP_W'(1);
      top <= mem[sp - SP_W'(2)];
    end
  end

endmodule

// File: rtl/dvg_decoder.sv
// Fetches 16-bit DVG words over the byte port (1-cycle read latency, 3 cycles/word),
// executes flow ops internally, and holds each beam command until cmd_ready.
module dvg_decoder
  import dvg_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int ADDR_W      = 13
) (
  input  logic              dvgclk,
  input  logic              reset,
  input  logic              go,
  output logic [ADDR_W-1:0] dvga,
  input  logic [7:0]        dvgd,
  output logic              halted,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_abs,
  output logic [10:0]       cmd_dx,
  output logic [10:0]       cmd_dy,
  output logic [3:0]        cmd_scale,
  output logic [3:0]        cmd_z
);

  localparam int PC_W = ADDR_W - 1;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [7:0]      lo;
  logic [15:0]     w0;
  logic [3:0]      w1_top;
  logic [10:0]     w1_xs;
  logic            second;
  logic            push, pop, clear, ld_cmd;
  logic [PC_W-1:0] top;
  logic [3:0]      op;

  assign op        = w0[15:12];
  assign halted    = (state == S_IDLE);
  assign cmd_valid = (state == S_EMIT);

  dvg_retstack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
    .dvgclk   (dvgclk),
    .reset    (reset),
    .clear    (clear),
    .push     (push),
    .pop      (pop),
    .push_dat (pc),
    .top      (top)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    pop       = 1'b0;
    clear     = 1'b0;
    ld_cmd    = 1'b0;
    case (state)
      S_IDLE: if (go) begin
        state_nxt = S_ADDR;
        pc_nxt    = '0;
        clear     = 1'b1;
      end
      S_ADDR: state_nxt = S_RDLO;
      S_RDLO: state_nxt = S_RDHI;
      S_RDHI: begin
        pc_nxt    = pc + PC_W'(1);
        state_nxt = (!second && dvgd[7:4] <= OP_LABS) ? S_ADDR : S_DECODE;
      end
      S_DECODE: begin
        state_nxt = S_ADDR;
        case (op)
          OP_HALT: state_nxt = S_IDLE;
          OP_JSRL: begin push = 1'b1; pc_nxt = w0[PC_W-1:0]; end
          OP_RTSL: begin pop = 1'b1; pc_nxt = top; end
          OP_JMPL: pc_nxt = w0[PC_W-1:0];
          default: begin ld_cmd = 1'b1; state_nxt = S_EMIT; end
        endcase
      end
      S_EMIT:  if (cmd_ready) state_nxt = S_ADDR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge dvgclk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      dvga      <= '0;
      lo        <= '0;
      w0        <= '0;
      w1_top    <= '0;
      w1_xs     <= '0;
      second    <= 1'b0;
      cmd_abs   <= 1'b0;
      cmd_dx    <= '0;
      cmd_dy    <= '0;
      cmd_scale <= '0;
      cmd_z     <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      // dvga leads the read state by one cycle so dvgd lands in RDLO/RDHI.
      if (state_nxt == S_ADDR) dvga <= {pc_nxt, 1'b0};
      else if (state_nxt == S_RDLO) dvga <= {pc, 1'b1};
      if (state == S_RDLO) lo <= dvgd;
      if (state == S_RDHI) begin
        second <= !second && (dvgd[7:4] <= OP_LABS);
        if (!second) w0 <= {dvgd, lo};
        else begin
          w1_top <= dvgd[7:4];
          w1_xs  <= {dvgd[2:0], lo};
        end
      end
      if (ld_cmd) begin
        if (op == OP_LABS) begin
          cmd_abs   <= 1'b1;
          cmd_dx    <= {1'b0, w1_xs[9:0]};
          cmd_dy    <= {1'b0, w0[9:0]};
          cmd_scale <= w1_top;
          cmd_z     <= 4'd0;
        end else if (op == OP_SVEC) begin
          cmd_abs   <= 1'b0;
          cmd_dx    <= sm2c(w0[2], {8'd0, w0[1:0]});
          cmd_dy    <= sm2c(w0[10], {8'd0, w0[9:8]});
          cmd_scale <= 4'd2 + {2'b00, w0[11], w0[3]};
          cmd_z     <= w0[7:4];
        end else begin
          cmd_abs   <= 1'b0;
          cmd_dx    <= sm2c(w1_xs[10], w1_xs[9:0]);
          cmd_dy    <= sm2c(w0[10], w0[9:0]);
          cmd_scale <= op;
          cmd_z     <= w1_top;
        end
      end
    end
  end

endmodule

// File: tb/tb_dvg_decoder.sv
// Scoreboard bench: an instruction-level interpreter of the vector list predicts the
// beam commands, and a monitor compares every cycle the DUT presents cmd_valid.
module tb_dvg_decoder;

  logic        dvgclk = 1'b0;
  logic        reset, go, cmd_ready;
  logic [12:0] dvga;
  logic [7:0]  dvgd;
  logic        halted, cmd_valid, cmd_abs;
  logic [10:0] cmd_dx, cmd_dy;
  logic [3:0]  cmd_scale, cmd_z;

  always #5 dvgclk = ~dvgclk;

  dvg_decoder #(.STACK_DEPTH(4), .ADDR_W(13)) dut (
    .dvgclk    (dvgclk),
    .reset     (reset),
    .go        (go),
    .dvga      (dvga),
    .dvgd      (dvgd),
    .halted    (halted),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_abs   (cmd_abs),
    .cmd_dx    (cmd_dx),
    .cmd_dy    (cmd_dy),
    .cmd_scale (cmd_scale),
    .cmd_z     (cmd_z)
  );

  logic [7:0] mem [0:8191];
  always @(posedge dvgclk) dvgd <= mem[dvga];

  typedef struct packed {
    logic        abs;
    logic [10:0] dx;
    logic [10:0] dy;
    logic [3:0]  scale;
    logic [3:0]  z;
  } cmd_t;

  cmd_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   rand_rdy = 1'b0;
  logic rdy_force = 1'b1;
  cmd_t mon_e, mon_g;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge dvgclk);
    #1;
    cmd_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
  endtask

  task automatic put(input int a, input logic [15:0] w);
    mem[(a * 2) % 8192]     = w[7:0];
    mem[(a * 2 + 1) % 8192] = w[15:8];
  endtask

  function automatic logic [15:0] rd_word(input int p);
    return {mem[(p * 2 + 1) % 8192], mem[(p * 2) % 8192]};
  endfunction

  function automatic logic [10:0] smc(input int sign, input int mag);
    int v;
    v = sign ? -mag : mag;
    return v[10:0];
  endfunction

  // Interprets the list from word 0 until HALT or max_cmds beam commands.
  task automatic model(input int max_cmds);
    int pc = 0;
    int sp = 0;
    int stk[4] = '{default: 0};
    int n = 0;
    int op;
    logic [15:0] w0, w1;
    cmd_t c;
    for (int step = 0; step < 5000; step++) begin
      w0 = rd_word(pc);
      pc = (pc + 1) % 4096;
      op = int'(w0[15:12]);
      w1 = 16'h0;
      if (op <= 10) begin
        w1 = rd_word(pc);
        pc = (pc + 1) % 4096;
      end
      if (op == 11) return;
      if (op <= 10 || op == 15) begin
        if (op <= 9) begin
          c.abs = 1'b0; c.scale = 4'(op); c.z = w1[15:12];
          c.dx = smc(int'(w1[10]), int'(w1[9:0]));
          c.dy = smc(int'(w0[10]), int'(w0[9:0]));
        end else if (op == 10) begin
          c.abs = 1'b1; c.scale = w1[15:12]; c.z = 4'd0;
          c.dx = 11'(int'(w1[9:0]));
          c.dy = 11'(int'(w0[9:0]));
        end else begin
          c.abs = 1'b0; c.z = w0[7:4];
          c.scale = 4'(2 + 2 * int'(w0[11]) + int'(w0[3]));
          c.dx = smc(int'(w0[2]), int'(w0[1:0]));
          c.dy = smc(int'(w0[10]), int'(w0[9:8]));
        end
        exp_q.push_back(c);
        n++;
        if (n >= max_cmds) return;
      end else if (op == 12) begin
        stk[sp] = pc;
        sp = (sp + 1) % 4;
        pc = int'(w0[11:0]);
      end else if (op == 13) begin
        sp = (sp + 3) % 4;
        pc = stk[sp];
      end else begin
        pc = int'(w0[11:0]);
      end
    end
  endtask

  always @(negedge dvgclk) begin
    if (!reset && cmd_valid) begin
      mon_g = {cmd_abs, cmd_dx, cmd_dy, cmd_scale, cmd_z};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_cmd: got abs=%0d dx=%h dy=%h scale=%h z=%h, required no command",
                 mon_g.abs, mon_g.dx, mon_g.dy, mon_g.scale, mon_g.z);
      end else begin
        mon_e = exp_q[0];
        if (mon_g !== mon_e) begin
          fails++;
          $display("FAIL cmd: got abs=%0d dx=%h dy=%h scale=%h z=%h, required abs=%0d dx=%h dy=%h scale=%h z=%h",
                   mon_g.abs, mon_g.dx, mon_g.dy, mon_g.scale, mon_g.z,
                   mon_e.abs, mon_e.dx, mon_e.dy, mon_e.scale, mon_e.z);
        end
        if (cmd_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_valid(input string name);
    int k;
    for (k = 0; k < 200 && !cmd_valid; k++) tick();
    chk(name, 32'(cmd_valid), 32'd1);
  endtask

  task automatic wait_halt(input string name);
    int k;
    for (k = 0; k < 4000 && !halted; k++) tick();
    chk(name, 32'(halted), 32'd1);
  endtask

  task automatic run_prog(input string name, input int max_cmds, input bit exp_halt, input bit go_mid);
    int cyc;
    model(max_cmds);
    go = 1'b1;
    tick();
    go = 1'b0;
    for (cyc = 0; cyc < 4000; cyc++) begin
      if (exp_halt ? halted : (exp_q.size() == 0)) break;
      if (go_mid && cyc == 6) begin
        go = 1'b1;
        tick();
        go = 1'b0;
      end else begin
        tick();
      end
    end
    chk({name, "_finished"}, 32'(cyc < 4000), 32'd1);
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    if (!exp_halt) begin
      chk({name, "_running"}, 32'(halted), 32'd0);
      do_reset();
    end
    exp_q.delete();
    rand_rdy  = 1'b0;
    rdy_force = 1'b1;
    cmd_ready = 1'b1;
  endtask

  task automatic put_draw(inout int a);
    int k;
    k = $urandom_range(0, 2);
    if (k == 0) begin
      put(a, {4'($urandom_range(0, 9)), 12'($urandom)});
      put(a + 1, 16'($urandom));
      a += 2;
    end else if (k == 1) begin
      put(a, {4'hA, 12'($urandom)});
      put(a + 1, 16'($urandom));
      a += 2;
    end else begin
      put(a, {4'hF, 12'($urandom)});
      a += 1;
    end
  endtask

  task automatic gen_prog();
    int a, n, r;
    clear_mem();
    for (int s = 0; s < 2; s++) begin
      a = 'h800 + 'h40 * s;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) put_draw(a);
      put(a, 16'hD000);
    end
    a = 0;
    n = $urandom_range(3, 8);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r == 6 || r == 7) begin
        put(a, 16'hC000 | 16'('h800 + 'h40 * (r - 6)));
        a += 1;
      end else if (r == 8) begin
        put(a, 16'hE000 | 16'(a + 2));
        put(a + 1, 16'hB000);
        a += 2;
      end else begin
        put_draw(a);
      end
    end
    put(a, 16'hB000);
  endtask

  initial begin
    reset     = 1'b1;
    go        = 1'b0;
    cmd_ready = 1'b1;
    clear_mem();
    tick();
    tick();
    tick();
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_dvga", 32'(dvga), 32'd0);
    chk("rst_cmd_data", 32'({cmd_abs, cmd_dx, cmd_dy, cmd_scale, cmd_z}), 32'd0);
    reset = 1'b0;
    tick();

    // HALT only: address sequence and halted timing.
    put(0, 16'hB000);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("halt_started", 32'(halted), 32'd0);
    chk("halt_dvga_lo", 32'(dvga), 32'h0000);
    tick();
    chk("halt_dvga_hi", 32'(dvga), 32'h0001);
    wait_halt("halt_halted");

    clear_mem();
    put(0, 16'h3105); put(1, 16'h7203); put(2, 16'hB000);
    run_prog("vctr", 1000, 1'b1, 1'b0);

    // LABS held for 10 stalled cycles, then one acceptance.
    clear_mem();
    put(0, 16'hA064); put(1, 16'h1080); put(2, 16'hB000);
    model(1000);
    rdy_force = 1'b0;
    cmd_ready = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_valid("labs_valid");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("labs_hold", 32'(cmd_valid), 32'd1);
    end
    rdy_force = 1'b1;
    cmd_ready = 1'b1;
    wait_halt("labs_halted");
    chk("labs_drained", 32'(exp_q.size()), 32'd0);

    clear_mem();
    put(0, 16'hC800); put(1, 16'hB000); put('h800, 16'hF570); put('h801, 16'hD000);
    run_prog("jsrl_svec", 1000, 1'b1, 1'b0);

    // Five nested calls on a 4-deep stack; the wrapped returns loop forever.
    clear_mem();
    put(0, 16'hC010); put(1, 16'hB000);
    for (int k = 1; k <= 4; k++) begin
      put('h10 * k, 16'hC000 | 16'('h10 * (k + 1)));
      put('h10 * k + 1, {4'(k), 12'($urandom)});
      put('h10 * k + 2, 16'($urandom));
      put('h10 * k + 3, 16'hD000);
    end
    put('h50, {4'hF, 12'($urandom)});
    put('h51, 16'hD000);
    run_prog("nested", 12, 1'b0, 1'b0);

    // Reset while a command is stalled.
    clear_mem();
    put(0, 16'h5123); put(1, 16'h9456); put(2, 16'hB000);
    model(1000);
    rdy_force = 1'b0;
    cmd_ready = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_valid("stall_valid");
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("stallrst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("stallrst_halted", 32'(halted), 32'd1);
    chk("stallrst_dvga", 32'(dvga), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    rdy_force = 1'b1;
    cmd_ready = 1'b1;
    tick();

    for (int i = 0; i < 20; i++) begin
      gen_prog();
      rand_rdy = 1'b1;
      run_prog("random", 1000, 1'b1, 1'(i % 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
